clink_lut_arbiter: RTL and testbench
====================================

# clink_lut_arbiter

Arbitrates the shared activation LUT (sigmoid/tanh table) among the CLINK datapath requesters: MVM, REC and host-side table readback. Grants are round-robin and burst-locked, so a requester keeps the LUT until it flags the last beat. Each accepted beat returns a response-valid strobe to its owner after a fixed LUT read latency. A watchdog forcibly releases a grant that is held too long. The block sits between the requesters and the LUT's address port, replacing the fixed MVM/REC address mux.

## Interface
- N_REQ, 3, number of requesters (index 0 = MVM, 1 = REC, 2 = HOST)
- ADDR_W, 10, LUT address width
- LUT_LAT, 1, LUT read latency in cycles (legal 1..4)
- MAX_HOLD, 64, maximum cycles a single grant may be held (≥2)
- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester beat request
- req_last  in  N_REQ  final beat of burst; qualified by req&gnt
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice k = [k*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot-or-zero registered grant
- lut_en  out  1  LUT read enable
- lut_addr  out  ADDR_W  LUT read address
- rsp_valid  out  N_REQ  one-hot LUT data valid for owner
- busy  out  1  a grant is active
- hold_err  out  1  sticky; watchdog forced a release

## Operation
- States: IDLE (no grant) and BUSY (gnt[k]=1 for the owner k).
- Winner selection: among asserted req bits, the first index at or after ptr, scanning upward with wrap. ptr resets to 0.
- IDLE: if any req is high, gnt for the winner is registered at the next edge and the state goes to BUSY. If no req is high, the state stays IDLE.
- BUSY, beat: a beat is a cycle with req[k]&gnt[k]. During a beat, lut_en=1 and lut_addr=req_addr slice k, combinationally. With no beat, lut_en=0 and lut_addr=0.
- BUSY, pause: req[k] low with no last keeps the grant. This is a legal pause.
- Release: a beat with req_last[k]=1 ends the grant and sets ptr=(k+1) mod N_REQ.
  - On the same edge, the winner among the other pending requesters is granted immediately (zero bubble).
  - If nothing else is pending, the state goes to IDLE.
  - The released requester's own req in that cycle is not considered.
- Watchdog: hold_cnt clears on every new grant and increments each BUSY cycle.
  - If the MAX_HOLD-th cycle of a grant passes without a last beat, the grant is released exactly as above and hold_err is set.
  - A beat in that final cycle is still accepted and still returns a response.
  - hold_err is cleared only by reset.
- Responses: rsp_valid is the beat vector (req&gnt) delayed by exactly LUT_LAT cycles in a shift pipeline. Pauses produce gaps in the pipeline.
- Requesters must not assert req_last without req. req_last outside a grant is ignored.
- Reset, at any time including mid-burst: gnt, busy, lut_en, lut_addr, rsp_valid, hold_err, ptr and hold_cnt all go to 0. In-flight responses are discarded.

## Timing
- Reset values: every output is 0.
- Arbitration latency: 1 cycle from req (in IDLE) to gnt.
- Beat-to-rsp_valid latency: LUT_LAT cycles.
- Sustained throughput: 1 beat/cycle, including across owner handover.
- gnt, busy, hold_err and rsp_valid are registered. lut_en and lut_addr are combinational from registered gnt plus the inputs.

## Structure
- Shared package clink_pkg: CLINK_LUT_ADDR_W=10, requester index constants REQ_MVM=0, REQ_REC=1, REQ_HOST=2, state encoding constants for IDLE/BUSY.
- Sub-module clink_rr_pick: combinational rotate-priority picker (inputs req mask and ptr, outputs one-hot winner and a valid flag). It is instantiated once.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- Single REC burst, LUT_LAT=1:
  - Stimulus: req[1] for 4 cycles, addresses 0x010–0x013, req_last on the 4th.
  - Required: gnt=3'b010 one cycle after req. lut_addr steps 0x010–0x013 with lut_en=1. rsp_valid[1] follows each beat by 1 cycle. gnt returns to 0 after the last beat.
- All three requesters asserted on the first cycle after reset, 2-beat bursts each:
  - Required: grants 0, 1, 2 in order with no idle cycle between owners. Six consecutive lut_en=1 cycles.
- Fairness:
  - Stimulus: req0 issues continuous single-beat bursts; req2 issues single-beat bursts.
  - Required: grant sequence 0, 2, 0, 2…; req0 never receives two consecutive grants while req2 is pending.
- Pause:
  - Stimulus: REC drops req for 3 cycles mid-burst, then resumes.
  - Required: gnt[1] held throughout; lut_en=0 and lut_addr=0 during the pause; rsp_valid shows a matching 3-cycle gap.
- Watchdog, MAX_HOLD=8:
  - Stimulus: MVM holds req with no last while HOST is pending.
  - Required: gnt[0] lasts exactly 8 cycles, then gnt[2] is asserted on the next cycle and hold_err=1 stays set.
- Reset mid-burst, LUT_LAT=3, with 2 beats in flight:
  - Required: all outputs are 0 on the cycle after reset is sampled, and no rsp_valid is ever emitted for the in-flight beats.

Source files
------------

// File: rtl/clink_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clink_pkg
// Description : Shared CLINK constants: LUT geometry, requester indices and
//               LUT arbiter state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package clink_pkg;

    localparam int CLINK_LUT_ADDR_W = 10;
    localparam int CLINK_N_REQ      = 3;

    localparam int REQ_MVM  = 0;
    localparam int REQ_REC  = 1;
    localparam int REQ_HOST = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage : clink_pkg
`default_nettype wire

// File: rtl/clink_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : clink_rr_pick
// Description : Combinational rotate-priority picker. Returns the first set
//               bit of req_mask at or after ptr (upward, with wrap), one-hot.
// Revision    : 1.0 - initial release
// ============================================================================
module clink_rr_pick
    import clink_pkg::*;
#(
    parameter int N_REQ = CLINK_N_REQ,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_mask,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic             valid
);

    logic [2*N_REQ-1:0] w_rot_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [N_REQ-1:0]   w_rot_win;
    logic [2*N_REQ-1:0] w_back_dbl;

    // Rotate so that index ptr lands at bit 0, isolate the lowest set bit,
    // then rotate the one-hot result back to absolute requester positions.
    assign w_rot_dbl  = {req_mask, req_mask} >> ptr;
    assign w_rot      = w_rot_dbl[N_REQ-1:0];
    assign w_rot_win  = w_rot & (~w_rot + 1'b1);
    assign w_back_dbl = {w_rot_win, w_rot_win} << ptr;

    assign winner = w_back_dbl[2*N_REQ-1:N_REQ];
    assign valid  = |req_mask;

endmodule : clink_rr_pick
`default_nettype wire

// File: rtl/clink_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : clink_lut_arbiter
// Description : Round-robin, burst-locked arbiter for the shared activation
//               LUT with hold watchdog and fixed-latency response strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module clink_lut_arbiter
    import clink_pkg::*;
#(
    parameter int N_REQ    = CLINK_N_REQ,
    parameter int ADDR_W   = CLINK_LUT_ADDR_W,
    parameter int LUT_LAT  = 1,
    parameter int MAX_HOLD = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    output logic [N_REQ-1:0]        gnt,
    output logic                    lut_en,
    output logic [ADDR_W-1:0]       lut_addr,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic                    busy,
    output logic                    hold_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_nxt;
    logic             r_hold_err;
    logic             w_hold_err_nxt;

    logic [N_REQ-1:0] w_beat;
    logic             w_last_beat;
    logic             w_timeout;
    logic [PTR_W-1:0] w_owner;
    logic [PTR_W-1:0] w_ptr_after;

    logic [N_REQ-1:0] w_pick_mask;
    logic [PTR_W-1:0] w_pick_ptr;
    logic [N_REQ-1:0] w_pick_win;
    logic             w_pick_valid;

    logic [N_REQ-1:0] r_rsp_pipe [LUT_LAT];

    assign w_beat      = req & r_gnt;
    assign w_last_beat = |(w_beat & req_last);
    assign w_timeout   = (r_state == ST_BUSY) && (r_hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        w_owner = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_gnt[k]) begin
                w_owner = PTR_W'(k);
            end
        end
    end

    assign w_ptr_after = (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + 1'b1;

    // On release the scan starts just past the owner and excludes it, which
    // makes the handover both fair and bubble-free.
    assign w_pick_mask = (r_state == ST_BUSY) ? (req & ~r_gnt) : req;
    assign w_pick_ptr  = (r_state == ST_BUSY) ? w_ptr_after : r_ptr;

    clink_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_mask (w_pick_mask),
        .ptr      (w_pick_ptr),
        .winner   (w_pick_win),
        .valid    (w_pick_valid)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_ptr_nxt      = r_ptr;
        w_hold_cnt_nxt = r_hold_cnt;
        w_hold_err_nxt = r_hold_err;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt      = w_pick_win;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                if (w_last_beat || w_timeout) begin
                    w_ptr_nxt      = w_ptr_after;
                    w_hold_cnt_nxt = '0;
                    if (w_timeout && !w_last_beat) begin
                        w_hold_err_nxt = 1'b1;
                    end
                    if (w_pick_valid) begin
                        w_gnt_nxt   = w_pick_win;
                        w_state_nxt = ST_BUSY;
                    end else begin
                        w_gnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_hold_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
            r_hold_err <= w_hold_err_nxt;
        end
    end

    // Beat vector delayed by the LUT read latency; reset drops in-flight beats.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LUT_LAT; i++) begin
                r_rsp_pipe[i] <= '0;
            end
        end else begin
            r_rsp_pipe[0] <= w_beat;
            for (int i = 1; i < LUT_LAT; i++) begin
                r_rsp_pipe[i] <= r_rsp_pipe[i-1];
            end
        end
    end

    always_comb begin
        lut_addr = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_beat[k]) begin
                lut_addr = req_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign lut_en    = |w_beat;
    assign gnt       = r_gnt;
    assign busy      = (r_state == ST_BUSY);
    assign hold_err  = r_hold_err;
    assign rsp_valid = r_rsp_pipe[LUT_LAT-1];

endmodule : clink_lut_arbiter
`default_nettype wire

// File: tb/tb_clink_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clink_lut_arbiter
// Description : Directed self-checking bench; DUT A has LUT_LAT=1/MAX_HOLD=8,
//               DUT B has LUT_LAT=3/MAX_HOLD=64, both on the same inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clink_lut_arbiter;

    logic        clock;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_last;
    logic [29:0] req_addr;

    logic [2:0]  gnt_a, rsp_a, gnt_b, rsp_b;
    logic        lut_en_a, busy_a, hold_err_a;
    logic        lut_en_b, busy_b, hold_err_b;
    logic [9:0]  lut_addr_a, lut_addr_b;

    int checks   = 0;
    int failures = 0;

    clink_lut_arbiter #(
        .N_REQ (3), .ADDR_W (10), .LUT_LAT (1), .MAX_HOLD (8)
    ) u_dut_a (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .gnt       (gnt_a),
        .lut_en    (lut_en_a),
        .lut_addr  (lut_addr_a),
        .rsp_valid (rsp_a),
        .busy      (busy_a),
        .hold_err  (hold_err_a)
    );

    clink_lut_arbiter #(
        .N_REQ (3), .ADDR_W (10), .LUT_LAT (3), .MAX_HOLD (64)
    ) u_dut_b (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .gnt       (gnt_b),
        .lut_en    (lut_en_b),
        .lut_addr  (lut_addr_b),
        .rsp_valid (rsp_b),
        .busy      (busy_b),
        .hold_err  (hold_err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle, drive that cycle's inputs, settle.
    task automatic step(input logic [2:0] r, input logic [2:0] l,
                        input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2);
        @(posedge clock);
        #1;
        req      = r;
        req_last = l;
        req_addr = {a2, a1, a0};
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_last = '0;
        req_addr = '0;

        // Reset values
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        reset = 1'b0;
        chk("rst_gnt",      gnt_a,      3'b000);
        chk("rst_busy",     busy_a,     1'b0);
        chk("rst_lut_en",   lut_en_a,   1'b0);
        chk("rst_lut_addr", lut_addr_a, 10'h0);
        chk("rst_rsp",      rsp_a,      3'b000);
        chk("rst_hold_err", hold_err_a, 1'b0);
        chk("rst_gnt_b",    gnt_b,      3'b000);

        // Single REC burst
        step(3'b010, 3'b000, 10'h0, 10'h010, 10'h0);
        chk("s1_c0_gnt",    gnt_a,      3'b000);
        chk("s1_c0_lut_en", lut_en_a,   1'b0);
        step(3'b010, 3'b000, 10'h0, 10'h010, 10'h0);
        chk("s1_c1_gnt",    gnt_a,      3'b010);
        chk("s1_c1_lut_en", lut_en_a,   1'b1);
        chk("s1_c1_addr",   lut_addr_a, 10'h010);
        chk("s1_c1_rsp",    rsp_a,      3'b000);
        chk("s1_c1_busy",   busy_a,     1'b1);
        step(3'b010, 3'b000, 10'h0, 10'h011, 10'h0);
        chk("s1_c2_addr",   lut_addr_a, 10'h011);
        chk("s1_c2_rsp",    rsp_a,      3'b010);
        step(3'b010, 3'b000, 10'h0, 10'h012, 10'h0);
        chk("s1_c3_addr",   lut_addr_a, 10'h012);
        chk("s1_c3_rsp",    rsp_a,      3'b010);
        step(3'b010, 3'b010, 10'h0, 10'h013, 10'h0);
        chk("s1_c4_addr",   lut_addr_a, 10'h013);
        chk("s1_c4_gnt",    gnt_a,      3'b010);
        chk("s1_c4_rsp_b",  rsp_b,      3'b010);
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        chk("s1_c5_gnt",    gnt_a,      3'b000);
        chk("s1_c5_busy",   busy_a,     1'b0);
        chk("s1_c5_lut_en", lut_en_a,   1'b0);
        chk("s1_c5_rsp",    rsp_a,      3'b010);
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        chk("s1_c6_rsp",    rsp_a,      3'b000);
        do_reset();

        // All three requesters, 2-beat bursts, zero-bubble handover
        step(3'b111, 3'b000, 10'h100, 10'h200, 10'h300);
        chk("s2_c0_gnt",    gnt_a,      3'b000);
        step(3'b111, 3'b000, 10'h100, 10'h200, 10'h300);
        chk("s2_c1_gnt",    gnt_a,      3'b001);
        chk("s2_c1_en",     lut_en_a,   1'b1);
        chk("s2_c1_addr",   lut_addr_a, 10'h100);
        step(3'b111, 3'b001, 10'h101, 10'h200, 10'h300);
        chk("s2_c2_gnt",    gnt_a,      3'b001);
        chk("s2_c2_en",     lut_en_a,   1'b1);
        chk("s2_c2_addr",   lut_addr_a, 10'h101);
        chk("s2_c2_rsp",    rsp_a,      3'b001);
        step(3'b110, 3'b000, 10'h0, 10'h200, 10'h300);
        chk("s2_c3_gnt",    gnt_a,      3'b010);
        chk("s2_c3_en",     lut_en_a,   1'b1);
        chk("s2_c3_addr",   lut_addr_a, 10'h200);
        step(3'b110, 3'b010, 10'h0, 10'h201, 10'h300);
        chk("s2_c4_gnt",    gnt_a,      3'b010);
        chk("s2_c4_en",     lut_en_a,   1'b1);
        chk("s2_c4_addr",   lut_addr_a, 10'h201);
        step(3'b100, 3'b000, 10'h0, 10'h0, 10'h300);
        chk("s2_c5_gnt",    gnt_a,      3'b100);
        chk("s2_c5_en",     lut_en_a,   1'b1);
        chk("s2_c5_addr",   lut_addr_a, 10'h300);
        chk("s2_c5_rsp",    rsp_a,      3'b010);
        step(3'b100, 3'b100, 10'h0, 10'h0, 10'h301);
        chk("s2_c6_gnt",    gnt_a,      3'b100);
        chk("s2_c6_en",     lut_en_a,   1'b1);
        chk("s2_c6_addr",   lut_addr_a, 10'h301);
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        chk("s2_c7_gnt",    gnt_a,      3'b000);
        chk("s2_c7_en",     lut_en_a,   1'b0);
        chk("s2_c7_rsp",    rsp_a,      3'b100);
        do_reset();

        // Fairness: MVM and HOST both issue single-beat bursts every cycle
        step(3'b101, 3'b101, 10'h0AA, 10'h0, 10'h2BB);
        chk("s3_c0_gnt", gnt_a, 3'b000);
        for (int i = 1; i <= 6; i++) begin
            step(3'b101, 3'b101, 10'h0AA, 10'h0, 10'h2BB);
            chk($sformatf("s3_c%0d_gnt", i),  gnt_a,      (i % 2 == 1) ? 3'b001 : 3'b100);
            chk($sformatf("s3_c%0d_addr", i), lut_addr_a, (i % 2 == 1) ? 10'h0AA : 10'h2BB);
        end
        do_reset();

        // Pause mid-burst
        step(3'b010, 3'b000, 10'h0, 10'h040, 10'h0);
        chk("s4_c0_gnt",    gnt_a,      3'b000);
        step(3'b010, 3'b000, 10'h0, 10'h040, 10'h0);
        chk("s4_c1_gnt",    gnt_a,      3'b010);
        chk("s4_c1_addr",   lut_addr_a, 10'h040);
        step(3'b010, 3'b000, 10'h0, 10'h041, 10'h0);
        chk("s4_c2_addr",   lut_addr_a, 10'h041);
        chk("s4_c2_rsp",    rsp_a,      3'b010);
        step(3'b000, 3'b000, 10'h0, 10'h042, 10'h0);
        chk("s4_c3_gnt",    gnt_a,      3'b010);
        chk("s4_c3_en",     lut_en_a,   1'b0);
        chk("s4_c3_addr",   lut_addr_a, 10'h000);
        chk("s4_c3_rsp",    rsp_a,      3'b010);
        step(3'b000, 3'b000, 10'h0, 10'h042, 10'h0);
        chk("s4_c4_gnt",    gnt_a,      3'b010);
        chk("s4_c4_rsp",    rsp_a,      3'b000);
        step(3'b000, 3'b000, 10'h0, 10'h042, 10'h0);
        chk("s4_c5_gnt",    gnt_a,      3'b010);
        chk("s4_c5_en",     lut_en_a,   1'b0);
        chk("s4_c5_rsp",    rsp_a,      3'b000);
        step(3'b010, 3'b010, 10'h0, 10'h042, 10'h0);
        chk("s4_c6_en",     lut_en_a,   1'b1);
        chk("s4_c6_addr",   lut_addr_a, 10'h042);
        chk("s4_c6_rsp",    rsp_a,      3'b000);
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        chk("s4_c7_gnt",    gnt_a,      3'b000);
        chk("s4_c7_rsp",    rsp_a,      3'b010);
        do_reset();

        // Watchdog: MVM never flags last while HOST waits
        step(3'b101, 3'b000, 10'h077, 10'h0, 10'h088);
        chk("s5_c0_gnt",      gnt_a,      3'b000);
        chk("s5_c0_hold_err", hold_err_a, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(3'b101, 3'b000, 10'h077, 10'h0, 10'h088);
            chk($sformatf("s5_c%0d_gnt", i),      gnt_a,      3'b001);
            chk($sformatf("s5_c%0d_hold_err", i), hold_err_a, 1'b0);
        end
        step(3'b100, 3'b100, 10'h077, 10'h0, 10'h088);
        chk("s5_c9_gnt",        gnt_a,      3'b100);
        chk("s5_c9_hold_err",   hold_err_a, 1'b1);
        chk("s5_c9_rsp",        rsp_a,      3'b001);
        chk("s5_c9_addr",       lut_addr_a, 10'h088);
        chk("s5_c9_gnt_b",      gnt_b,      3'b001);
        chk("s5_c9_hold_err_b", hold_err_b, 1'b0);
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        chk("s5_c10_gnt",       gnt_a,      3'b000);
        chk("s5_c10_busy",      busy_a,     1'b0);
        chk("s5_c10_hold_err",  hold_err_a, 1'b1);
        step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
        chk("s5_c11_hold_err",  hold_err_a, 1'b1);
        do_reset();
        chk("s5_rst_hold_err",  hold_err_a, 1'b0);

        // Reset mid-burst with beats in flight (DUT B, LUT_LAT=3)
        step(3'b001, 3'b000, 10'h055, 10'h0, 10'h0);
        chk("s6_c0_gnt_b", gnt_b, 3'b000);
        step(3'b001, 3'b000, 10'h055, 10'h0, 10'h0);
        chk("s6_c1_gnt_b", gnt_b,    3'b001);
        chk("s6_c1_en_b",  lut_en_b, 1'b1);
        step(3'b001, 3'b000, 10'h056, 10'h0, 10'h0);
        chk("s6_c2_en_b",  lut_en_b, 1'b1);
        step(3'b001, 3'b000, 10'h057, 10'h0, 10'h0);
        reset = 1'b1;
        step(3'b001, 3'b000, 10'h058, 10'h0, 10'h0);
        reset = 1'b0;
        chk("s6_c4_gnt_b",      gnt_b,      3'b000);
        chk("s6_c4_busy_b",     busy_b,     1'b0);
        chk("s6_c4_en_b",       lut_en_b,   1'b0);
        chk("s6_c4_addr_b",     lut_addr_b, 10'h0);
        chk("s6_c4_rsp_b",      rsp_b,      3'b000);
        chk("s6_c4_hold_err_b", hold_err_b, 1'b0);
        chk("s6_c4_rsp_a",      rsp_a,      3'b000);
        for (int i = 5; i <= 9; i++) begin
            step(3'b000, 3'b000, 10'h0, 10'h0, 10'h0);
            chk($sformatf("s6_c%0d_rsp_b", i), rsp_b, 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_clink_lut_arbiter
`default_nettype wire
